// File: rtl/ex_branch_stage.sv
// Execute-stage branch resolution with a 2-entry result FIFO and a one-cycle fetch redirect pulse.
// Optional feature: define EX_BR_MISALIGN_EN to trap taken control transfers whose target[1] is set.
module ex_branch_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic        br_eq,
    input  logic        br_lt,
    input  logic [4:0]  rd,
    input  logic        reg_wen,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_wb_data,
    output logic [4:0]  out_rd,
    output logic        out_wen,
    output logic        out_exc,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] wb_data;
        logic [RW-1:0]   rd;
        logic            wen;
        logic            exc;
    } entry_t;

    state_t            state_q, state_d;
    entry_t            head_q, head_d, tail_q, tail_d;
    logic              in_ready_d, out_valid_d, redirect_valid_d;
    logic [XLEN-1:0]   redirect_pc_d;

    logic              cond_c, taken_c, misalign_c, accept_c, pop_c;
    logic [XLEN-1:0]   target_c;
    entry_t            new_c;

    // Resolve the incoming instruction into a FIFO entry and redirect target
    always_comb begin
        cond_c = 1'b0;
        case (funct3)
            3'b000:         cond_c = br_eq;
            3'b001:         cond_c = !br_eq;
            3'b100, 3'b110: cond_c = br_lt;
            3'b101, 3'b111: cond_c = !br_lt;
            default:        cond_c = 1'b0;
        endcase
        taken_c  = is_jal || is_jalr || (is_branch && cond_c);
        target_c = is_jalr ? {alu_result[XLEN-1:1], 1'b0} : XLEN'(pc + imm);
`ifdef EX_BR_MISALIGN_EN
        misalign_c = taken_c && target_c[1];
`else
        misalign_c = 1'b0;
`endif
        new_c.wb_data = (is_jal || is_jalr) ? XLEN'(pc + XLEN'(4)) : alu_result;
        new_c.rd      = rd;
        new_c.wen     = reg_wen && !is_branch && (rd != RW'(0)) && !misalign_c;
        new_c.exc     = misalign_c;
    end

    // Beats arriving in the redirect shadow are wrong-path and are dropped
    assign accept_c = in_valid && in_ready && !redirect_valid;
    assign pop_c    = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (accept_c) begin
                    state_d = ONE;
                    head_d  = new_c;
                end
            end
            ONE: begin
                if (accept_c && pop_c) begin
                    head_d = new_c;
                end else if (accept_c) begin
                    state_d = TWO;
                    tail_d  = new_c;
                end else if (pop_c) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop_c) begin
                    state_d = ONE;
                    head_d  = tail_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        redirect_valid_d = accept_c && taken_c && !misalign_c;
        redirect_pc_d    = redirect_valid_d ? target_c : redirect_pc;
        in_ready_d       = (state_d != TWO) || redirect_valid_d;
        out_valid_d      = (state_d != EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= EMPTY;
            head_q         <= '0;
            tail_q         <= '0;
            in_ready       <= 1'b0;
            out_valid      <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state_q        <= state_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            in_ready       <= in_ready_d;
            out_valid      <= out_valid_d;
            redirect_valid <= redirect_valid_d;
            redirect_pc    <= redirect_pc_d;
        end
    end

    assign out_wb_data = head_q.wb_data;
    assign out_rd      = head_q.rd;
    assign out_wen     = head_q.wen;
    assign out_exc     = head_q.exc;

endmodule

// File: tb/tb_ex_branch_stage.sv
// Self-checking bench for ex_branch_stage: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_ex_branch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] pc, imm, alu_result;
    logic        is_branch, is_jal, is_jalr;
    logic [2:0]  funct3;
    logic        br_eq, br_lt;
    logic [4:0]  rd;
    logic        reg_wen;
    logic        out_valid, out_ready;
    logic [31:0] out_wb_data;
    logic [4:0]  out_rd;
    logic        out_wen, out_exc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] wb;
        logic [4:0]  rd;
        logic        wen;
        logic        exc;
    } exp_t;

    exp_t        q[$];
    logic        m_redir;
    logic [31:0] m_rpc;
    logic        m_rdy;

    always #5 clk = ~clk;

    ex_branch_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .imm(imm),
        .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
        .funct3(funct3), .alu_result(alu_result), .br_eq(br_eq), .br_lt(br_lt),
        .rd(rd), .reg_wen(reg_wen),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wb_data(out_wb_data), .out_rd(out_rd), .out_wen(out_wen), .out_exc(out_exc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int cls, input logic [2:0] f3,
                         input logic [31:0] p, input logic [31:0] im, input logic [31:0] alu,
                         input logic eq, input logic lt, input logic [4:0] r, input logic w);
        in_valid   = v;
        is_branch  = (cls == 1);
        is_jal     = (cls == 2);
        is_jalr    = (cls == 3);
        funct3     = f3;
        pc         = p;
        imm        = im;
        alu_result = alu;
        br_eq      = eq;
        br_lt      = lt;
        rd         = r;
        reg_wen    = w;
    endtask

    task automatic idle();
        drive(1'b0, 0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    // Reference behaviour for one rising edge, using the inputs currently applied
    task automatic model_edge();
        logic        acc, pop, tk, mis;
        logic [31:0] tgt;
        exp_t        e;
        acc = in_valid && m_rdy && !m_redir;
        pop = (q.size() > 0) && out_ready;
        if (is_jal || is_jalr) tk = 1'b1;
        else if (is_branch) begin
            if (funct3 == 3'd0)                         tk = br_eq;
            else if (funct3 == 3'd1)                    tk = !br_eq;
            else if (funct3 == 3'd4 || funct3 == 3'd6)  tk = br_lt;
            else if (funct3 == 3'd5 || funct3 == 3'd7)  tk = !br_lt;
            else                                        tk = 1'b0;
        end else tk = 1'b0;
        tgt = is_jalr ? (alu_result & 32'hFFFF_FFFE) : (pc + imm);
`ifdef EX_BR_MISALIGN_EN
        mis = tk && tgt[1];
`else
        mis = 1'b0;
`endif
        e.wb  = (is_jal || is_jalr) ? (pc + 32'd4) : alu_result;
        e.rd  = rd;
        e.wen = reg_wen && !is_branch && (rd != 5'd0) && !mis;
        e.exc = mis;
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(e);
        m_redir = acc && tk && !mis;
        if (m_redir) m_rpc = tgt;
        m_rdy = (q.size() < 2) || m_redir;
    endtask

    task automatic check_all();
        chk("in_ready", 32'(in_ready), 32'(m_rdy));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("redirect_valid", 32'(redirect_valid), 32'(m_redir));
        if (m_redir) chk("redirect_pc", redirect_pc, m_rpc);
        if (q.size() != 0) begin
            chk("out_wb_data", out_wb_data, q[0].wb);
            chk("out_rd", 32'(out_rd), 32'(q[0].rd));
            chk("out_wen", 32'(out_wen), 32'(q[0].wen));
            chk("out_exc", 32'(out_exc), 32'(q[0].exc));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_redirect_valid"}, 32'(redirect_valid), 32'd0);
        chk({tag, "_redirect_pc"}, redirect_pc, 32'd0);
        chk({tag, "_out_wb_data"}, out_wb_data, 32'd0);
        chk({tag, "_out_rd"}, 32'(out_rd), 32'd0);
        chk({tag, "_out_wen"}, 32'(out_wen), 32'd0);
        chk({tag, "_out_exc"}, 32'(out_exc), 32'd0);
    endtask

    task automatic model_reset();
        q.delete();
        m_redir = 1'b0;
        m_rpc   = 32'd0;
        m_rdy   = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        idle();
        model_reset();
        #1;
        check_reset_values("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);

        // BEQ taken: one-cycle redirect to pc+imm, branch never writes back
        drive(1'b1, 1, 3'b000, 32'h100, 32'h20, 32'h55, 1'b1, 1'b0, 5'd5, 1'b1);
        cycle();
        chk("beq_redirect_valid", 32'(redirect_valid), 32'd1);
        chk("beq_redirect_pc", redirect_pc, 32'h120);
        chk("beq_out_wen", 32'(out_wen), 32'd0);
        idle();
        cycle();
        chk("beq_redirect_drop", 32'(redirect_valid), 32'd0);

        // JALR: target has bit 0 cleared, link is pc+4
        drive(1'b1, 3, 3'b000, 32'h400, 32'h0, 32'h2003, 1'b0, 1'b0, 5'd1, 1'b1);
        cycle();
        chk("jalr_redirect_pc", redirect_pc, 32'h2002);
        chk("jalr_wb_data", out_wb_data, 32'h404);
        chk("jalr_wen", 32'(out_wen), 32'd1);
        idle();
        cycle();

        // Backpressure: two beats fill the FIFO, third is held off then drained in order
        out_ready = 1'b0;
        drive(1'b1, 0, 3'b000, 32'h0, 32'h0, 32'hA1, 1'b0, 1'b0, 5'd2, 1'b1);
        cycle();
        drive(1'b1, 0, 3'b000, 32'h0, 32'h0, 32'hB2, 1'b0, 1'b0, 5'd3, 1'b1);
        cycle();
        drive(1'b1, 0, 3'b000, 32'h0, 32'h0, 32'hC3, 1'b0, 1'b0, 5'd4, 1'b1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        cycle();
        chk("held_in_ready", 32'(in_ready), 32'd0);
        chk("held_head", out_wb_data, 32'hA1);
        out_ready = 1'b1;
        cycle();
        chk("drain_1", out_wb_data, 32'hB2);
        cycle();
        idle();
        chk("drain_2", out_wb_data, 32'hC3);
        cycle();
        chk("drain_empty", 32'(out_valid), 32'd0);

        // BLT taken, then a wrong-path beat during the redirect cycle must vanish
        drive(1'b1, 1, 3'b100, 32'h200, 32'hFFFF_FFF8, 32'hAAAA, 1'b0, 1'b1, 5'd3, 1'b1);
        cycle();
        chk("blt_redirect_pc", redirect_pc, 32'h1F8);
        chk("shadow_in_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 0, 3'b000, 32'h0, 32'h0, 32'hDEAD, 1'b0, 1'b0, 5'd7, 1'b1);
        cycle();
        chk("shadow_killed", 32'(out_valid), 32'd0);
        idle();
        cycle();

        // JAL at the top of the address space: link wraps to 0, rd=0 suppresses write
        drive(1'b1, 2, 3'b000, 32'hFFFF_FFFC, 32'h8, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
        cycle();
        chk("jal_wrap_wb", out_wb_data, 32'h0);
        chk("jal_rd0_wen", 32'(out_wen), 32'd0);
        chk("jal_wrap_target", redirect_pc, 32'h4);
        idle();
        cycle();

        // BNE taken to a halfword-aligned target
        drive(1'b1, 1, 3'b001, 32'h100, 32'h2, 32'h0, 1'b0, 1'b0, 5'd6, 1'b0);
        cycle();
`ifdef EX_BR_MISALIGN_EN
        chk("misalign_no_redirect", 32'(redirect_valid), 32'd0);
        chk("misalign_exc", 32'(out_exc), 32'd1);
        chk("misalign_wen", 32'(out_wen), 32'd0);
`else
        chk("misalign_redirect", 32'(redirect_valid), 32'd1);
        chk("misalign_redirect_pc", redirect_pc, 32'h102);
        chk("misalign_exc_tied", 32'(out_exc), 32'd0);
`endif
        idle();
        cycle();

        // Randomized traffic against the reference model
        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)), 3'($urandom),
                  ($urandom_range(0, 1) != 0) ? ($urandom & 32'hFFFF_FFFC) : 32'($urandom),
                  ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 64)) : 32'($urandom),
                  32'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), 1'($urandom));
            out_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end

        // Asynchronous reset in the middle of traffic drops everything
        out_ready = 1'b0;
        drive(1'b1, 2, 3'b000, 32'h800, 32'h10, 32'h0, 1'b0, 1'b0, 5'd9, 1'b1);
        cycle();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_values("mid");
        idle();
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_branch_stage.md
EX_BRANCH_STAGE -- requirements
Module: ex_branch_stage

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports in_valid input 1 and in_ready output 1  upstream (ALU stage) handshake.
REQ-004 SHALL have ports pc input 32 and imm input 32  instruction PC and sign-extended immediate.
REQ-005 SHALL have ports is_branch, is_jal, is_jalr  input  1 each  instruction class, at most one set.
REQ-006 SHALL have port funct3  input  3  branch condition code.
REQ-007 SHALL have ports alu_result input 32, br_eq input 1, br_lt input 1  ALU outputs; br_lt already signed/unsigned-resolved upstream.
REQ-008 SHALL have ports rd input 5 and reg_wen input 1  destination register and write enable.
REQ-009 SHALL have ports out_valid output 1 and out_ready input 1  downstream (writeback) handshake.
REQ-010 SHALL have ports out_wb_data output 32, out_rd output 5, out_wen output 1, out_exc output 1  queued result.
REQ-011 SHALL have ports redirect_valid output 1 and redirect_pc output 32  fetch redirect pulse.

Function
REQ-012 SHALL accept a beat when in_valid && in_ready, and emit one when out_valid && out_ready.
REQ-013 SHALL buffer beats in a 2-entry FIFO with states EMPTY, ONE, TWO; in_ready = (state != TWO), registered.
REQ-014 SHALL transition: EMPTY+push->ONE; ONE+push-only->TWO; ONE+pop-only->EMPTY; ONE+push+pop->ONE; TWO+pop->ONE; TWO never pushes.
REQ-015 SHALL drive out_valid = (state != EMPTY) and present the oldest entry on out_* ports; entry order preserved.
REQ-016 SHALL compute taken on accept: funct3 000 br_eq, 001 !br_eq, 100/110 br_lt, 101/111 !br_lt, 010/011 0; is_jal/is_jalr force taken=1.
REQ-017 SHALL compute target = pc+imm for is_branch/is_jal and {alu_result[31:1],1'b0} for is_jalr; 32-bit wrap-around, no overflow flag.
REQ-018 SHALL store wb_data = pc+4 (mod 2^32) for is_jal/is_jalr, else alu_result; wen = reg_wen && !is_branch && rd!=0.
REQ-019 SHALL assert redirect_valid for exactly one cycle, the cycle after accepting a taken instruction, with redirect_pc = its target.
REQ-020 SHALL, while redirect_valid=1, hold in_ready=1 and discard any in_valid beat (wrong-path shadow kill), no state change from it.
REQ-021 SHALL keep out_* stable while out_valid && !out_ready.
REQ-022 SHALL give 1-cycle latency accept->out_valid when EMPTY.

Reset
REQ-023 SHALL on rst_n=0 asynchronously force state=EMPTY, in_ready=0, out_valid=0, redirect_valid=0, redirect_pc=0, out_wb_data=0, out_rd=0, out_wen=0, out_exc=0.
REQ-024 SHALL raise in_ready to 1 on the first clock edge after rst_n deasserts; reset mid-operation drops all buffered entries and any pending redirect.

Configuration
REQ-025 SHALL, with EX_BR_MISALIGN_EN defined, for a taken instruction with target[1]=1: suppress redirect, store entry with out_exc=1 and out_wen=0.
REQ-026 SHALL, without EX_BR_MISALIGN_EN, tie out_exc to 0 and redirect to target regardless of target[1].

Verification
REQ-027 SHALL test BEQ pc=0x100 imm=0x20 br_eq=1 -> next cycle redirect_valid=1, redirect_pc=0x120, out_wen=0; cycle after redirect_valid=0.
REQ-028 SHALL test JALR alu_result=0x2003 pc=0x400 rd=1 reg_wen=1 -> redirect_pc=0x2002, out_wb_data=0x404, out_wen=1.
REQ-029 SHALL test out_ready=0 with 3 back-to-back non-branch beats -> in_ready=0 after 2 accepts, third held; out_ready=1 drains in order.
REQ-030 SHALL test BLT taken then in_valid beat during redirect cycle -> beat discarded, never appears on out_*.
REQ-031 SHALL test JAL pc=0xFFFFFFFC -> out_wb_data=0x00000000 (wrap); rd=0 -> out_wen=0.
REQ-032 SHALL test EX_BR_MISALIGN_EN defined, BNE taken target=0x102 -> redirect_valid stays 0, out_exc=1; without macro redirect_pc=0x102.
